// File: rtl/ble_pkt_pkg.sv
// Shared types and constants for the Bluefruit button-packet parser: '!' 'B' <id> <state> <checksum>.
package ble_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TYPE  = 3'd1,
    ID    = 3'd2,
    STATE = 3'd3,
    CSUM  = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_BANG = 8'h21;
  localparam logic [7:0] ASCII_B    = 8'h42;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_1    = 8'h31;
  localparam logic [7:0] ASCII_8    = 8'h38;

  localparam logic [3:0] BTN_UP    = 4'd5;
  localparam logic [3:0] BTN_DOWN  = 4'd6;
  localparam logic [3:0] BTN_LEFT  = 4'd7;
  localparam logic [3:0] BTN_RIGHT = 4'd8;

  // Button ids travel as ASCII '1'..'8'.
  function automatic logic is_btn_byte(input logic [7:0] b);
    return (b >= ASCII_1) && (b <= ASCII_8);
  endfunction

  function automatic logic [7:0] btn_mask(input logic [3:0] id);
    logic [7:0] m;
    m = 8'b1 << (id - 4'd1);
    return m;
  endfunction

endpackage

// File: rtl/ble_button_parser.sv
// Frames UART bytes into 5-byte button packets, emits checked press/release events and a held bitmap.
// Latency 1 cycle after the checksum byte; valid-only input, no backpressure; BLE_PKT_TIMEOUT_EN adds an inter-byte timeout.
module ble_button_parser
  import ble_pkt_pkg::*;
#(
  parameter int ERR_W          = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic             cmd_valid_out,
  output logic [3:0]       cmd_id_out,
  output logic             cmd_pressed_out,
  output logic [7:0]       cmd_byte_out,
  output logic [7:0]       held_out,
  output logic [ERR_W-1:0] err_count_out,
  output logic             busy_out
);

  state_e           state_q, state_d;
  logic [7:0]       sum_q, sum_d;
  logic [3:0]       id_q, id_d;
  logic             pressed_q, pressed_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [3:0]       cmd_id_q, cmd_id_d;
  logic             cmd_pressed_q, cmd_pressed_d;
  logic [7:0]       held_q, held_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pkt_good;
  logic             pkt_err;

`ifdef BLE_PKT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  // The counter only matters mid-packet; any byte restarts the idle window.
  always_comb begin
    timeout_hit = 1'b0;
    cnt_d       = '0;
    if (!valid_in && (state_q != IDLE)) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    id_d          = id_q;
    pressed_d     = pressed_q;
    cmd_valid_d   = 1'b0;
    cmd_id_d      = cmd_id_q;
    cmd_pressed_d = cmd_pressed_q;
    held_d        = held_q;
    err_d         = err_q;
    pkt_good      = 1'b0;
    pkt_err       = 1'b0;

    if (valid_in) begin
      unique case (state_q)
        IDLE: begin
          if (data_in == ASCII_BANG) begin
            state_d = TYPE;
            sum_d   = data_in;
          end
        end
        TYPE: begin
          if (data_in == ASCII_B) begin
            state_d = ID;
            sum_d   = sum_q + data_in;
          end else if (data_in == ASCII_BANG) begin
            sum_d = data_in;
          end else begin
            state_d = IDLE;
            pkt_err = 1'b1;
          end
        end
        ID: begin
          if (is_btn_byte(data_in)) begin
            state_d = STATE;
            id_d    = data_in[3:0];
            sum_d   = sum_q + data_in;
          end else begin
            state_d = IDLE;
            pkt_err = 1'b1;
          end
        end
        STATE: begin
          if ((data_in == ASCII_0) || (data_in == ASCII_1)) begin
            state_d   = CSUM;
            pressed_d = data_in[0];
            sum_d     = sum_q + data_in;
          end else begin
            state_d = IDLE;
            pkt_err = 1'b1;
          end
        end
        CSUM: begin
          state_d = IDLE;
          if (data_in == ~sum_q) begin
            pkt_good = 1'b1;
          end else begin
            pkt_err = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef BLE_PKT_TIMEOUT_EN
    else if (timeout_hit) begin
      state_d = IDLE;
      pkt_err = 1'b1;
    end
`endif

    if (pkt_good) begin
      cmd_valid_d   = 1'b1;
      cmd_id_d      = id_q;
      cmd_pressed_d = pressed_q;
      held_d        = (held_q & ~btn_mask(id_q)) | (pressed_q ? btn_mask(id_q) : 8'h00);
    end

    if (pkt_err && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      sum_q         <= '0;
      id_q          <= '0;
      pressed_q     <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_id_q      <= '0;
      cmd_pressed_q <= 1'b0;
      held_q        <= '0;
      err_q         <= '0;
`ifdef BLE_PKT_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      id_q          <= id_d;
      pressed_q     <= pressed_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_id_q      <= cmd_id_d;
      cmd_pressed_q <= cmd_pressed_d;
      held_q        <= held_d;
      err_q         <= err_d;
`ifdef BLE_PKT_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign cmd_valid_out   = cmd_valid_q;
  assign cmd_id_out      = cmd_id_q;
  assign cmd_pressed_out = cmd_pressed_q;
  assign cmd_byte_out    = {cmd_pressed_q, 3'b000, cmd_id_q};
  assign held_out        = held_q;
  assign err_count_out   = err_q;
  assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_ble_button_parser.sv
// Bench for ble_button_parser: queue-based packet model checked every cycle, plus directed literal cases.
module tb_ble_button_parser;
  import ble_pkt_pkg::*;

  localparam int TB_ERR_W = 4;
`ifdef BLE_PKT_TIMEOUT_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 65536;
`endif
  localparam int ERR_MAX = (1 << TB_ERR_W) - 1;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [7:0]          data_in;
  logic                valid_in;
  logic                cmd_valid_out;
  logic [3:0]          cmd_id_out;
  logic                cmd_pressed_out;
  logic [7:0]          cmd_byte_out;
  logic [7:0]          held_out;
  logic [TB_ERR_W-1:0] err_count_out;
  logic                busy_out;

  ble_button_parser #(.ERR_W(TB_ERR_W), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .cmd_valid_out   (cmd_valid_out),
    .cmd_id_out      (cmd_id_out),
    .cmd_pressed_out (cmd_pressed_out),
    .cmd_byte_out    (cmd_byte_out),
    .held_out        (held_out),
    .err_count_out   (err_count_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: the bytes of the packet collected so far, and the outputs they imply.
  logic [7:0] pkt[$];
  logic       m_vld   = 1'b0;
  logic [3:0] m_id    = '0;
  logic       m_pr    = 1'b0;
  logic [7:0] m_held  = '0;
  int         m_err   = 0;
  int         cyc     = 0;
  int         last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_err();
    if (m_err < ERR_MAX) m_err++;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] s;
    int         idx;
    case (pkt.size())
      0: if (b == 8'h21) pkt.push_back(b);
      1: begin
        if (b == 8'h42) pkt.push_back(b);
        else if (b != 8'h21) begin pkt.delete(); model_err(); end
      end
      2: begin
        if (b >= 8'h31 && b <= 8'h38) pkt.push_back(b);
        else begin pkt.delete(); model_err(); end
      end
      3: begin
        if (b == 8'h30 || b == 8'h31) pkt.push_back(b);
        else begin pkt.delete(); model_err(); end
      end
      default: begin
        s = pkt[0] + pkt[1] + pkt[2] + pkt[3];
        if (b == ~s) begin
          m_vld = 1'b1;
          m_id  = pkt[2][3:0];
          m_pr  = pkt[3][0];
          idx   = int'(pkt[2][3:0]) - 1;
          m_held[idx] = pkt[3][0];
        end else begin
          model_err();
        end
        pkt.delete();
      end
    endcase
  endfunction

  always @(posedge clk_in) begin
    cyc++;
    m_vld = 1'b0;
    if (rst_in) begin
      pkt.delete();
      m_id = '0; m_pr = 1'b0; m_held = '0; m_err = 0;
    end else if (valid_in) begin
      last_cyc = cyc;
      model_byte(data_in);
    end
`ifdef BLE_PKT_TIMEOUT_EN
    else if (pkt.size() != 0 && (cyc - last_cyc) == TB_TO) begin
      pkt.delete();
      model_err();
    end
`endif
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("cmd_valid", 32'(cmd_valid_out), 32'(m_vld));
      chk("cmd_id", 32'(cmd_id_out), 32'(m_id));
      chk("cmd_pressed", 32'(cmd_pressed_out), 32'(m_pr));
      chk("cmd_byte", 32'(cmd_byte_out), 32'({m_pr, 3'b000, m_id}));
      chk("held", 32'(held_out), 32'(m_held));
      chk("err_count", 32'(err_count_out), 32'(m_err));
      chk("busy", 32'(busy_out), 32'(pkt.size() != 0));
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk_in); #1;
    data_in  = b;
    valid_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      valid_in = 1'b0;
      data_in  = 8'($urandom);
    end
  endtask

  task automatic send5(input logic [7:0] a, b, c, d, e);
    send(a); send(b); send(c); send(d); send(e);
  endtask

  task automatic pulse_reset();
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    rst_in   = 1'b1;
    @(posedge clk_in); #1;
    rst_in   = 1'b0;
  endtask

  task automatic rand_packet(input bit corrupt, input int keep);
    logic [7:0] p[5];
    logic [3:0] id;
    int         pos;
    id   = 4'(1 + $urandom_range(0, 7));
    p[0] = 8'h21;
    p[1] = 8'h42;
    p[2] = 8'h30 + 8'(id);
    p[3] = 8'h30 + 8'($urandom_range(0, 1));
    p[4] = ~(p[0] + p[1] + p[2] + p[3]);
    if (corrupt) begin
      pos    = $urandom_range(0, 4);
      p[pos] = 8'($urandom);
    end
    for (int i = 0; i < keep; i++) begin
      send(p[i]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    rst_in   = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    chk_en = 1'b1;

    @(negedge clk_in);
    chk("reset cmd_byte", 32'(cmd_byte_out), 32'h00);
    chk("reset held", 32'(held_out), 32'h00);
    chk("reset busy", 32'(busy_out), 32'h0);

    // Press UP.
    send5(8'h21, 8'h42, 8'h35, 8'h31, 8'h36); idle(1);
    @(negedge clk_in);
    chk("up press pulse", 32'(cmd_valid_out), 32'h1);
    chk("up press id", 32'(cmd_id_out), 32'h5);
    chk("up press byte", 32'(cmd_byte_out), 32'h85);
    chk("up press held", 32'(held_out), 32'h10);

    // Release UP.
    send5(8'h21, 8'h42, 8'h35, 8'h30, 8'h37); idle(1);
    @(negedge clk_in);
    chk("up release byte", 32'(cmd_byte_out), 32'h05);
    chk("up release held", 32'(held_out), 32'h00);
    chk("up release err", 32'(err_count_out), 32'h0);

    // Bad checksum.
    send5(8'h21, 8'h42, 8'h31, 8'h31, 8'h3B); idle(1);
    @(negedge clk_in);
    chk("bad csum pulse", 32'(cmd_valid_out), 32'h0);
    chk("bad csum err", 32'(err_count_out), 32'h1);
    chk("bad csum held", 32'(held_out), 32'h00);

    // Junk then double '!' resync.
    send(8'h55); send(8'h21);
    send5(8'h21, 8'h42, 8'h31, 8'h31, 8'h3A); idle(1);
    @(negedge clk_in);
    chk("resync pulse", 32'(cmd_valid_out), 32'h1);
    chk("resync id", 32'(cmd_id_out), 32'h1);
    chk("resync held", 32'(held_out), 32'h01);
    chk("resync err", 32'(err_count_out), 32'h1);

    // Reset mid-packet discards the partial packet.
    send(8'h21); send(8'h42);
    pulse_reset();
    @(negedge clk_in);
    chk("midrst busy", 32'(busy_out), 32'h0);
    chk("midrst err", 32'(err_count_out), 32'h0);
    send(8'h35); send(8'h31); send(8'h36); idle(1);
    @(negedge clk_in);
    chk("midrst tail pulse", 32'(cmd_valid_out), 32'h0);
    chk("midrst tail busy", 32'(busy_out), 32'h0);

    // Stalled partial packet.
    send(8'h21); send(8'h42); idle(16);
    @(negedge clk_in);
`ifdef BLE_PKT_TIMEOUT_EN
    chk("stall busy", 32'(busy_out), 32'h0);
    chk("stall err", 32'(err_count_out), 32'h1);
    send5(8'h21, 8'h42, 8'h38, 8'h31, 8'h33); idle(1);
`else
    chk("stall busy", 32'(busy_out), 32'h1);
    chk("stall err", 32'(err_count_out), 32'h0);
    send(8'h38); send(8'h31); send(8'h33); idle(1);
`endif
    @(negedge clk_in);
    chk("right pulse", 32'(cmd_valid_out), 32'h1);
    chk("right id", 32'(cmd_id_out), 32'h8);
    chk("right held", 32'(held_out), 32'h80);
    chk("right byte", 32'(cmd_byte_out), 32'h88);

    // A byte on the last idle cycle of the window beats the timeout.
    pulse_reset();
    send(8'h21); idle(15); send(8'h42); idle(15);
    @(negedge clk_in);
    chk("edge busy", 32'(busy_out), 32'h1);
    idle(1);
    @(negedge clk_in);
`ifdef BLE_PKT_TIMEOUT_EN
    chk("edge expire busy", 32'(busy_out), 32'h0);
    chk("edge expire err", 32'(err_count_out), 32'h1);
`else
    chk("edge expire busy", 32'(busy_out), 32'h1);
    chk("edge expire err", 32'(err_count_out), 32'h0);
`endif

    // Error counter saturation.
    pulse_reset();
    repeat (ERR_MAX + 5) begin send(8'h21); send(8'h00); end
    idle(1);
    @(negedge clk_in);
    chk("sat err", 32'(err_count_out), 32'(ERR_MAX));
    send5(8'h21, 8'h42, 8'h36, 8'h31, 8'h35); idle(1);
    @(negedge clk_in);
    chk("sat good pulse", 32'(cmd_valid_out), 32'h1);
    chk("sat good held", 32'(held_out), 32'h20);

    // Randomized traffic, checked every cycle by the model.
    pulse_reset();
    for (int it = 0; it < 2500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60)      rand_packet(1'b0, 5);
      else if (r < 75) rand_packet(1'b1, 5);
      else if (r < 85) send(8'($urandom));
      else if (r < 92) begin
        rand_packet(1'b0, $urandom_range(1, 4));
        idle($urandom_range(0, 20));
      end
      else if (r < 98) idle($urandom_range(1, 20));
      else             pulse_reset();
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ble_button_parser.md
Name: ble_button_parser

Overview:
- Sits between the BLE UART byte receiver and the gameplay controller.
- Frames the raw 8-bit byte stream into Bluefruit-style 5-byte button packets: '!' 'B' <id> <state> <checksum>.
- Validates each packet and emits one-cycle button events plus a held-button bitmap.
- Replaces raw byte forwarding into gameplay with checked, decoded commands.

Parameters:
- ERR_W, 8, width of the saturating error counter.
- TIMEOUT_CYCLES, 65536, maximum idle cycles between bytes of one packet (timeout feature only); about 0.88 ms at 74.25 MHz.

Ports:
- clk_in  input  1  pixel clock (74.25 MHz).
- rst_in  input  1  synchronous, active-high reset.
- data_in  input  8  received UART byte.
- valid_in  input  1  one-cycle strobe; data_in is valid this cycle.
- cmd_valid_out  output  1  one-cycle pulse; a good packet was decoded.
- cmd_id_out  output  4  button number 1..8 (5=up, 6=down, 7=left, 8=right).
- cmd_pressed_out  output  1  1=press, 0=release.
- cmd_byte_out  output  8  {cmd_pressed_out, 3'b0, cmd_id_out}; drop-in for gameplay user_input.
- held_out  output  8  bit k-1 set while button k is held.
- err_count_out  output  ERR_W  saturating count of rejected packets.
- busy_out  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; checksum accumulator 0. This applies mid-packet too: a partial packet is discarded and not counted as an error.
- The FSM advances only on cycles with valid_in=1. With valid_in=0 all state holds, except the timeout counter.
- The accumulator sum[7:0] wraps mod 256. It loads data_in on '!' and adds each later byte before the checksum byte.
- FSM states and transitions:
  - IDLE: 0x21 -> TYPE, sum=0x21. Any other byte is ignored (no error).
  - TYPE: 0x42 -> ID. 0x21 -> stay in TYPE, sum=0x21 (resync, no error). Otherwise -> IDLE, error.
  - ID: 0x31..0x38 -> STATE, id latched as data_in[3:0]. Otherwise -> IDLE, error.
  - STATE: 0x30 or 0x31 -> CSUM, pressed=data_in[0]. Otherwise -> IDLE, error.
  - CSUM: if data_in == ~sum, this is a good packet. Otherwise it is an error. Either way -> IDLE.
- Good packet, on the cycle after the checksum byte's valid_in (latency 1):
  - cmd_valid_out=1 for exactly one cycle.
  - cmd_id_out, cmd_pressed_out and cmd_byte_out update and then hold until the next good packet.
  - held_out[id-1] is set to pressed on the same cycle.
- Error: err_count_out += 1, saturating at all-ones. cmd_* and held_out are unchanged.
- Back-to-back packets with a single idle cycle between bytes must decode. A valid_in arriving in the same cycle as cmd_valid_out is accepted normally.
- A repeated press of a held button still pulses cmd_valid_out. held_out is unchanged.

Optional Feature:
- Macro: BLE_PKT_TIMEOUT_EN.
- With the macro: a counter clears on every valid_in and counts while busy_out=1. When it reaches TIMEOUT_CYCLES-1 with no byte, the FSM goes to IDLE and err_count_out increments. A valid_in on that same cycle wins over the timeout: the byte is processed and there is no timeout.
- Without the macro: no counter is built, and a stalled partial packet waits indefinitely.

Decomposition:
- Shared package ble_pkt_pkg holds:
  - the state enum (IDLE, TYPE, ID, STATE, CSUM);
  - constants ASCII_BANG=8'h21, ASCII_B=8'h42, ASCII_0=8'h30, ASCII_1=8'h31, ASCII_8=8'h38;
  - button id localparams BTN_UP=5, BTN_DOWN=6, BTN_LEFT=7, BTN_RIGHT=8.
- No sub-module is warranted: the accumulator and timeout counter are inline. The block stays single-module.

Test Plan:
- Bytes 21 42 35 31 36 -> one cmd_valid_out pulse 1 cycle after the last byte; cmd_id_out=5, cmd_pressed_out=1, cmd_byte_out=0x85, held_out=0x10.
- Then 21 42 35 30 37 -> cmd_pressed_out=0, cmd_byte_out=0x05, held_out=0x00; err_count_out stays 0.
- Bytes 21 42 31 31 3B (bad checksum; correct is 3A) -> no pulse, err_count_out=1, held_out unchanged.
- Bytes 55 21 21 42 31 31 3A -> leading junk is ignored and the double '!' resyncs; one pulse with cmd_id_out=1, held_out=0x01, err_count_out=0.
- Bytes 21 42 then assert rst_in for 1 cycle, then 35 31 36 -> no pulse, busy_out=0 after reset, err_count_out=0.
- With BLE_PKT_TIMEOUT_EN and TIMEOUT_CYCLES=16: bytes 21 42, then 16 idle cycles -> FSM returns to IDLE, err_count_out=1. A following full 21 42 38 31 33 -> cmd_id_out=8, held_out=0x80.
